// File: rtl/mem_swap_pkg.sv
// Shared step codes and checker state encodings for the swap datapath.
package mem_swap_pkg;
  localparam logic [1:0] STEP_NONE  = 2'b00;
  localparam logic [1:0] STEP_LOAD  = 2'b01;
  localparam logic [1:0] STEP_MOVE  = 2'b10;
  localparam logic [1:0] STEP_STORE = 2'b11;

  typedef logic [1:0] chk_state_t;
  localparam chk_state_t CHK_IDLE = 2'd0;
  localparam chk_state_t CHK_GOT1 = 2'd1;
  localparam chk_state_t CHK_GOT2 = 2'd2;
endpackage

// File: rtl/mem_swap_seq_chk.sv
// Step-stream sequence checker: only LOAD -> MOVE -> STORE on consecutive cycles is legal.
module mem_swap_seq_chk
  import mem_swap_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       w,
  input  logic [1:0] sel,
  output logic       step_ok,
  output logic       abort,
  output logic       seq_err
);
  chk_state_t state;
  chk_state_t state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CHK_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    step_ok    = 1'b0;
    abort      = 1'b0;
    seq_err    = 1'b0;
    case (state)
      CHK_IDLE: begin
        if (w) begin
          if (sel == STEP_LOAD) begin
            step_ok    = 1'b1;
            state_next = CHK_GOT1;
          end else begin
            seq_err = 1'b1;
          end
        end
      end
      CHK_GOT1: begin
        if (w && sel == STEP_MOVE) begin
          step_ok    = 1'b1;
          state_next = CHK_GOT2;
        end else begin
          seq_err    = 1'b1;
          abort      = 1'b1;
          state_next = CHK_IDLE;
        end
      end
      CHK_GOT2: begin
        if (w && sel == STEP_STORE) begin
          step_ok    = 1'b1;
          state_next = CHK_IDLE;
        end else begin
          seq_err    = 1'b1;
          abort      = 1'b1;
          state_next = CHK_IDLE;
        end
      end
      default: state_next = CHK_IDLE;
    endcase
  end
endmodule

// File: rtl/mem_swap_datapath.sv
// Register-file memory executing 3-step swaps plus a host port.
// Optional step-sequence checking is enabled by defining SWAP_SEQ_CHECK_EN.
module mem_swap_datapath
  import mem_swap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     w,
  input  logic [1:0]               sel,
  input  logic [$clog2(DEPTH)-1:0] addr_a,
  input  logic [$clog2(DEPTH)-1:0] addr_b,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [WIDTH-1:0]         host_wdata,
  output logic [WIDTH-1:0]         host_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     host_wr_drop,
  output logic                     seq_err
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] tmp;
  logic [AW-1:0]    a_q;
  logic [AW-1:0]    b_q;

  logic step_ok;
  logic abort;
  logic chk_err;

`ifdef SWAP_SEQ_CHECK_EN
  mem_swap_seq_chk u_seq_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .w       (w),
    .sel     (sel),
    .step_ok (step_ok),
    .abort   (abort),
    .seq_err (chk_err)
  );
`else
  assign step_ok = w;
  assign abort   = 1'b0;
  assign chk_err = 1'b0;
`endif

  logic do_load, do_move, do_store, host_wr;
  assign do_load  = step_ok && (sel == STEP_LOAD);
  assign do_move  = step_ok && (sel == STEP_MOVE);
  assign do_store = step_ok && (sel == STEP_STORE);
  // The controller owns the memory whenever w is high; host writes lose.
  assign host_wr      = host_we && !w;
  assign host_wr_drop = host_we && w;
  assign seq_err      = chk_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_move) begin
      mem[a_q] <= mem[b_q];
    end else if (do_store) begin
      mem[b_q] <= tmp;
    end else if (host_wr) begin
      mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmp        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_rdata <= mem[host_addr];
      done       <= do_store;
      if (abort) begin
        tmp  <= '0;
        busy <= 1'b0;
      end else if (do_load) begin
        tmp  <= mem[addr_a];
        a_q  <= addr_a;
        b_q  <= addr_b;
        busy <= 1'b1;
      end else if (do_store) begin
        busy <= 1'b0;
      end
    end
  end
endmodule
